// File: rtl/mem_access_ctrl.sv
// Memory-stage access sequencer for the 16-bit-word data memory.
// Turns one pipeline request into one or two memory beats and owns the stack pointer.
module mem_access_ctrl #(
  parameter logic [31:0] SP_RESET = 32'h000F_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [15:0] i_wdata,
  input  logic [31:0] i_pc,
  input  logic [15:0] i_flags,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [15:0] o_rflags,
  output logic [31:0] o_sp,
  output logic        o_memRead,
  output logic        o_memWrite,
  output logic        o_en32,
  output logic        o_isStack,
  output logic [31:0] o_address,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] OpLdd  = 3'd0;
  localparam logic [2:0] OpStd  = 3'd1;
  localparam logic [2:0] OpPush = 3'd2;
  localparam logic [2:0] OpPop  = 3'd3;
  localparam logic [2:0] OpCall = 3'd4;
  localparam logic [2:0] OpRet  = 3'd5;
  localparam logic [2:0] OpInt  = 3'd6;
  localparam logic [2:0] OpRti  = 3'd7;

  localparam logic [31:0] SpDec1 = 32'hFFFF_FFFF;
  localparam logic [31:0] SpDec2 = 32'hFFFF_FFFE;
  localparam logic [31:0] SpInc1 = 32'h0000_0001;
  localparam logic [31:0] SpInc2 = 32'h0000_0002;

  typedef enum logic [2:0] {
    StIdle,
    StAcc1,
    StCap1,
    StAcc2,
    StCap2,
    StDone
  } state_e;

  // One memory beat: strobes, address, data and the SP step applied when it ends.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        en32;
    logic        stk;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] delta;
  } beat_t;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [15:0] flags_q;
  logic [31:0] sp_q;
  logic [31:0] delta_q;
  logic [31:0] rdata_q;
  logic [15:0] rflags_q;
  logic        busy_q;
  logic        done_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        en32_q;
  logic        is_stack_q;
  logic [31:0] address_q;
  logic [31:0] mem_wdata_q;

  beat_t       b1;
  beat_t       b2;
  logic [31:0] sp_base;

  // Beat 1 is decoded straight from the request so it can be registered on the accept edge.
  always_comb begin
    b1 = '0;
    unique case (i_op)
      OpLdd: begin
        b1.rd   = 1'b1;
        b1.addr = i_addr;
      end
      OpStd: begin
        b1.wr    = 1'b1;
        b1.addr  = i_addr;
        b1.wdata = {16'b0, i_wdata};
      end
      OpPush: begin
        b1.wr    = 1'b1;
        b1.stk   = 1'b1;
        b1.addr  = sp_q;
        b1.wdata = {16'b0, i_wdata};
        b1.delta = SpDec1;
      end
      OpPop, OpRti: begin
        b1.rd    = 1'b1;
        b1.stk   = 1'b1;
        b1.addr  = sp_q;
        b1.delta = SpInc1;
      end
      OpCall, OpInt: begin
        b1.wr    = 1'b1;
        b1.en32  = 1'b1;
        b1.stk   = 1'b1;
        b1.addr  = sp_q;
        b1.wdata = i_pc;
        b1.delta = SpDec2;
      end
      OpRet: begin
        b1.rd    = 1'b1;
        b1.en32  = 1'b1;
        b1.stk   = 1'b1;
        b1.addr  = sp_q + SpInc2;
        b1.delta = SpInc2;
      end
      default: b1 = '0;
    endcase
  end

  // Beat 2 is loaded on the ACC1 edge (INT) or the CAP1 edge (RTI); in the ACC1 case
  // the SP written on that same edge has to be anticipated.
  always_comb begin
    b2      = '0;
    sp_base = (state_q == StAcc1) ? sp_q + delta_q : sp_q;
    if (op_q == OpInt) begin
      b2.wr    = 1'b1;
      b2.stk   = 1'b1;
      b2.addr  = sp_base;
      b2.wdata = {16'b0, flags_q};
      b2.delta = SpDec1;
    end else if (op_q == OpRti) begin
      b2.rd    = 1'b1;
      b2.en32  = 1'b1;
      b2.stk   = 1'b1;
      b2.addr  = sp_base + SpInc2;
      b2.delta = SpInc2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= OpLdd;
      flags_q     <= '0;
      sp_q        <= SP_RESET;
      delta_q     <= '0;
      rdata_q     <= '0;
      rflags_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      en32_q      <= 1'b0;
      is_stack_q  <= 1'b0;
      address_q   <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_req) begin
            op_q        <= i_op;
            flags_q     <= i_flags;
            busy_q      <= 1'b1;
            mem_read_q  <= b1.rd;
            mem_write_q <= b1.wr;
            en32_q      <= b1.en32;
            is_stack_q  <= b1.stk;
            address_q   <= b1.addr;
            mem_wdata_q <= b1.wdata;
            delta_q     <= b1.delta;
            state_q     <= StAcc1;
          end
        end
        StAcc1: begin
          sp_q        <= sp_q + delta_q;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          en32_q      <= 1'b0;
          is_stack_q  <= 1'b0;
          if (mem_read_q) begin
            state_q <= StCap1;
          end else if (op_q == OpInt) begin
            mem_write_q <= b2.wr;
            en32_q      <= b2.en32;
            is_stack_q  <= b2.stk;
            address_q   <= b2.addr;
            mem_wdata_q <= b2.wdata;
            delta_q     <= b2.delta;
            state_q     <= StAcc2;
          end else begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StCap1: begin
          if (op_q == OpRti) begin
            rflags_q    <= i_mem_rdata[15:0];
            mem_read_q  <= b2.rd;
            en32_q      <= b2.en32;
            is_stack_q  <= b2.stk;
            address_q   <= b2.addr;
            delta_q     <= b2.delta;
            state_q     <= StAcc2;
          end else begin
            rdata_q <= (op_q == OpRet) ? i_mem_rdata : {16'b0, i_mem_rdata[15:0]};
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StAcc2: begin
          sp_q        <= sp_q + delta_q;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          en32_q      <= 1'b0;
          is_stack_q  <= 1'b0;
          if (mem_read_q) begin
            state_q <= StCap2;
          end else begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StCap2: begin
          rdata_q <= i_mem_rdata;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_rdata     = rdata_q;
  assign o_rflags    = rflags_q;
  assign o_sp        = sp_q;
  assign o_memRead   = mem_read_q;
  assign o_memWrite  = mem_write_q;
  assign o_en32      = en32_q;
  assign o_isStack   = is_stack_q;
  assign o_address   = address_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 16-bit-word data memory.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [2:0]  i_op;
  logic [31:0] i_addr;
  logic [15:0] i_wdata;
  logic [31:0] i_pc;
  logic [15:0] i_flags;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic [15:0] o_rflags;
  logic [31:0] o_sp;
  logic        o_memRead;
  logic        o_memWrite;
  logic        o_en32;
  logic        o_isStack;
  logic [31:0] o_address;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  int n_cmp;
  int n_err;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_op       (i_op),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .i_pc       (i_pc),
    .i_flags    (i_flags),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rdata    (o_rdata),
    .o_rflags   (o_rflags),
    .o_sp       (o_sp),
    .o_memRead  (o_memRead),
    .o_memWrite (o_memWrite),
    .o_en32     (o_en32),
    .o_isStack  (o_isStack),
    .o_address  (o_address),
    .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: 32-bit access at A is {mem[A-1], mem[A]}; stack 16-bit read returns mem[A+1].
  logic [15:0] mem [logic [31:0]];

  function automatic logic [15:0] mrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (o_memWrite) begin
      if (o_en32) begin
        mem[o_address - 32'd1] = o_mem_wdata[31:16];
        mem[o_address]         = o_mem_wdata[15:0];
      end else begin
        mem[o_address] = o_mem_wdata[15:0];
      end
    end
    if (o_memRead) begin
      if (o_en32)         i_mem_rdata <= {mrd(o_address - 32'd1), mrd(o_address)};
      else if (o_isStack) i_mem_rdata <= {16'h0000, mrd(o_address + 32'd1)};
      else                i_mem_rdata <= {16'h0000, mrd(o_address)};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic rd, input logic wr, input logic e32,
                         input logic stk);
    check({tag, ".memRead"}, {31'b0, o_memRead}, {31'b0, rd});
    check({tag, ".memWrite"}, {31'b0, o_memWrite}, {31'b0, wr});
    check({tag, ".en32"}, {31'b0, o_en32}, {31'b0, e32});
    check({tag, ".isStack"}, {31'b0, o_isStack}, {31'b0, stk});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a request for cycle 0 and returns one step into cycle 1.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [15:0] wd,
                       input logic [31:0] pc, input logic [15:0] fl);
    i_req   = 1'b1;
    i_op    = op;
    i_addr  = addr;
    i_wdata = wd;
    i_pc    = pc;
    i_flags = fl;
    step();
    i_req = 1'b0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_op    = 3'd0;
    i_addr  = '0;
    i_wdata = '0;
    i_pc    = '0;
    i_flags = '0;
    i_mem_rdata = '0;
    step();
    step();
    check("rst.sp", o_sp, 32'h000F_FFFF);
    check("rst.busy", {31'b0, o_busy}, 32'd0);
    check("rst.done", {31'b0, o_done}, 32'd0);
    check("rst.rdata", o_rdata, 32'd0);
    check("rst.address", o_address, 32'd0);
    chk_bus("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // PUSH 0xBEEF
    issue(3'd2, 32'h0, 16'hBEEF, 32'h0, 16'h0);
    chk_bus("push.c1", 1'b0, 1'b1, 1'b0, 1'b1);
    check("push.c1.addr", o_address, 32'h000F_FFFF);
    check("push.c1.wdata", o_mem_wdata, 32'h0000_BEEF);
    check("push.c1.busy", {31'b0, o_busy}, 32'd1);
    step();
    check("push.c2.done", {31'b0, o_done}, 32'd1);
    check("push.c2.sp", o_sp, 32'h000F_FFFE);
    chk_bus("push.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("push.c3.busy", {31'b0, o_busy}, 32'd0);
    check("push.c3.done", {31'b0, o_done}, 32'd0);

    // POP
    issue(3'd3, 32'h0, 16'h0, 32'h0, 16'h0);
    chk_bus("pop.c1", 1'b1, 1'b0, 1'b0, 1'b1);
    check("pop.c1.addr", o_address, 32'h000F_FFFE);
    step();
    check("pop.c2.done", {31'b0, o_done}, 32'd0);
    check("pop.c2.sp", o_sp, 32'h000F_FFFF);
    chk_bus("pop.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("pop.c3.done", {31'b0, o_done}, 32'd1);
    check("pop.c3.rdata", o_rdata, 32'h0000_BEEF);
    step();

    // CALL / RET
    issue(3'd4, 32'h0, 16'h0, 32'h0001_2345, 16'h0);
    chk_bus("call.c1", 1'b0, 1'b1, 1'b1, 1'b1);
    check("call.c1.addr", o_address, 32'h000F_FFFF);
    check("call.c1.wdata", o_mem_wdata, 32'h0001_2345);
    step();
    check("call.c2.done", {31'b0, o_done}, 32'd1);
    check("call.c2.sp", o_sp, 32'h000F_FFFD);
    step();
    issue(3'd5, 32'h0, 16'h0, 32'h0, 16'h0);
    chk_bus("ret.c1", 1'b1, 1'b0, 1'b1, 1'b1);
    check("ret.c1.addr", o_address, 32'h000F_FFFF);
    step();
    step();
    check("ret.c3.done", {31'b0, o_done}, 32'd1);
    check("ret.c3.rdata", o_rdata, 32'h0001_2345);
    check("ret.c3.sp", o_sp, 32'h000F_FFFF);
    step();

    // INT / RTI
    issue(3'd6, 32'h0, 16'h0, 32'h00AB_CDEF, 16'h0005);
    chk_bus("int.c1", 1'b0, 1'b1, 1'b1, 1'b1);
    check("int.c1.addr", o_address, 32'h000F_FFFF);
    check("int.c1.wdata", o_mem_wdata, 32'h00AB_CDEF);
    step();
    chk_bus("int.c2", 1'b0, 1'b1, 1'b0, 1'b1);
    check("int.c2.addr", o_address, 32'h000F_FFFD);
    check("int.c2.wdata", o_mem_wdata, 32'h0000_0005);
    check("int.c2.sp", o_sp, 32'h000F_FFFD);
    check("int.c2.done", {31'b0, o_done}, 32'd0);
    step();
    check("int.c3.done", {31'b0, o_done}, 32'd1);
    check("int.c3.sp", o_sp, 32'h000F_FFFC);
    chk_bus("int.c3", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    issue(3'd7, 32'h0, 16'h0, 32'h0, 16'h0);
    chk_bus("rti.c1", 1'b1, 1'b0, 1'b0, 1'b1);
    check("rti.c1.addr", o_address, 32'h000F_FFFC);
    step();
    chk_bus("rti.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rti.c2.sp", o_sp, 32'h000F_FFFD);
    step();
    chk_bus("rti.c3", 1'b1, 1'b0, 1'b1, 1'b1);
    check("rti.c3.addr", o_address, 32'h000F_FFFF);
    step();
    chk_bus("rti.c4", 1'b0, 1'b0, 1'b0, 1'b0);
    check("rti.c4.done", {31'b0, o_done}, 32'd0);
    step();
    check("rti.c5.done", {31'b0, o_done}, 32'd1);
    check("rti.c5.rflags", {16'b0, o_rflags}, 32'h0000_0005);
    check("rti.c5.rdata", o_rdata, 32'h00AB_CDEF);
    check("rti.c5.sp", o_sp, 32'h000F_FFFF);
    step();

    // STD / LDD with a request dropped while busy
    issue(3'd1, 32'h0000_0100, 16'h1234, 32'h0, 16'h0);
    chk_bus("std.c1", 1'b0, 1'b1, 1'b0, 1'b0);
    check("std.c1.addr", o_address, 32'h0000_0100);
    check("std.c1.wdata", o_mem_wdata, 32'h0000_1234);
    step();
    check("std.c2.done", {31'b0, o_done}, 32'd1);
    step();
    issue(3'd0, 32'h0000_0100, 16'h0, 32'h0, 16'h0);
    chk_bus("ldd.c1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("ldd.c1.addr", o_address, 32'h0000_0100);
    i_req   = 1'b1;
    i_op    = 3'd2;
    i_wdata = 16'hDEAD;
    step();
    i_req = 1'b0;
    chk_bus("ldd.c2", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("ldd.c3.done", {31'b0, o_done}, 32'd1);
    check("ldd.c3.rdata", o_rdata, 32'h0000_1234);
    check("ldd.c3.sp", o_sp, 32'h000F_FFFF);
    step();
    check("ldd.c4.busy", {31'b0, o_busy}, 32'd0);
    chk_bus("ldd.c4", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_bus("ldd.c5", 1'b0, 1'b0, 1'b0, 1'b0);
    check("ldd.c5.sp", o_sp, 32'h000F_FFFF);

    // Asynchronous reset during RTI CAP1
    issue(3'd7, 32'h0, 16'h0, 32'h0, 16'h0);
    step();
    rst_n = 1'b0;
    #1;
    check("arst.sp", o_sp, 32'h000F_FFFF);
    check("arst.busy", {31'b0, o_busy}, 32'd0);
    check("arst.done", {31'b0, o_done}, 32'd0);
    check("arst.rdata", o_rdata, 32'd0);
    check("arst.rflags", {16'b0, o_rflags}, 32'd0);
    chk_bus("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_bus($sformatf("arst.post%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("arst.post%0d.done", i), {31'b0, o_done}, 32'd0);
    end
    check("arst.post.sp", o_sp, 32'h000F_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Pipeline-side initiator for the 16-bit-word data memory. It accepts one memory-stage request at a time: load, store, push, pop, call, return, interrupt entry or interrupt return. For each request it sequences one or two accesses on the data-memory port (read/write strobes, 32-bit enable, stack-read flag, address, write data) and owns the stack pointer. Read data and completion go back to the pipeline through a busy/done handshake.

## Interface
- SP_RESET, 32'h000F_FFFF, stack pointer value after reset (top word of data memory)
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  request valid; sampled only when o_busy=0
- i_op  input  3  0 LDD, 1 STD, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6 INT, 7 RTI
- i_addr  input  32  effective address for LDD/STD
- i_wdata  input  16  store/push data
- i_pc  input  32  return PC for CALL/INT
- i_flags  input  16  flags for INT
- o_busy  output  1  high in every non-IDLE state
- o_done  output  1  one-cycle completion pulse
- o_rdata  output  32  LDD/POP: {16'b0, word}; RET/RTI: popped PC; holds until next done
- o_rflags  output  16  flags popped by RTI; holds until next RTI
- o_sp  output  32  current stack pointer
- o_memRead, o_memWrite, o_en32, o_isStack  output  1 each  memory strobes, registered
- o_address  output  32  memory word address, registered
- o_mem_wdata  output  32  memory write data, registered
- i_mem_rdata  input  32  memory read data, valid the cycle after a read strobe

## Operation
- Reset: state IDLE; o_sp=SP_RESET; all strobes, o_address, o_mem_wdata, o_rdata, o_rflags, o_done, o_busy = 0.
- Accept: i_req=1 and state IDLE. Latch i_op, i_addr, i_wdata, i_pc and i_flags. i_req while busy is ignored, not queued.
- Memory layout is fixed. A 32-bit access at address A covers {mem[A-1], mem[A]}, high half at A-1. A 16-bit read with isStack=1 returns mem[A+1].
- LDD: read, en32=0, isStack=0, addr=i_addr.
- STD: write, en32=0, addr=i_addr, data={16'b0,i_wdata}.
- PUSH: write, en32=0, isStack=1, addr=SP. SP-=1.
- POP: read, en32=0, isStack=1, addr=SP. SP+=1.
- CALL: write, en32=1, isStack=1, addr=SP, data=i_pc. SP-=2.
- RET: read, en32=1, isStack=1, addr=SP+2. SP+=2.
- INT, two beats:
  - Beat 1 is a CALL-style push of i_pc.
  - Beat 2 is a PUSH of i_flags at the updated SP.
  - Net SP-=3.
- RTI, two beats:
  - Beat 1 is a POP into o_rflags.
  - Beat 2 is a RET into o_rdata.
  - Net SP+=3.
- States: IDLE → ACC1 → [CAP1 if beat 1 reads] → [ACC2 → [CAP2] if two-beat op] → DONE → IDLE.
  - ACCn: strobes asserted for exactly one cycle.
  - CAPn: i_mem_rdata sampled.
  - DONE: o_done=1 and strobes low.
- SP updates on the clock edge ending each ACC beat. A beat-2 address uses the SP already updated by beat 1.
- SP arithmetic is modulo 2^32 with no overflow or underflow detection.
- Outside ACC states, all strobes and o_isStack are 0. o_memRead and o_memWrite are never both 1.
- Asynchronous reset at any state aborts the operation and restores reset values. A half-done INT/RTI is not completed.

## Timing
- Cycle 0 is the accept cycle.
- Write ops (STD, PUSH, CALL): ACC1 in cycle 1, o_done in cycle 2.
- Reads (LDD, POP, RET): ACC1 in cycle 1, CAP1 in cycle 2, o_done in cycle 3 with o_rdata valid.
- INT: ACC1 in cycle 1, ACC2 in cycle 2, o_done in cycle 3.
- RTI: ACC1 in cycle 1, CAP1 in cycle 2, ACC2 in cycle 3, CAP2 in cycle 4, o_done in cycle 5.
- o_busy rises in cycle 1 and falls the cycle after DONE. The earliest next accept is the cycle after DONE.
- o_sp reflects the new value from the cycle after the ACC edge.

## Test plan
- Reset → o_sp=0x000FFFFF; busy, done and all strobes 0; o_rdata=0. Assert rst_n low mid-RTI (CAP1) → same values immediately, no further strobes.
- PUSH 0xBEEF → cycle 1: memWrite=1, en32=0, addr 0xFFFFF, data 0x0000BEEF. Done in cycle 2, SP 0xFFFFE. Then POP → cycle 1: memRead=1, isStack=1, addr 0xFFFFE. Done in cycle 3, o_rdata=0x0000BEEF, SP 0xFFFFF.
- CALL pc=0x00012345 → en32 write at addr 0xFFFFF, SP 0xFFFFD. Then RET → en32 read at addr 0xFFFFF, o_rdata=0x00012345, SP 0xFFFFF.
- INT pc=0x00ABCDEF, flags=0x0005 → en32 write at 0xFFFFF, then 16-bit write of 0x0005 at 0xFFFFD. Done in cycle 3, SP 0xFFFFC. Then RTI → read at 0xFFFFC (isStack), then en32 read at 0xFFFFF. Done in cycle 5: o_rflags=0x0005, o_rdata=0x00ABCDEF, SP 0xFFFFF.
- STD addr 0x100, data 0x1234, then LDD 0x100 → o_rdata=0x00001234, SP unchanged. Pulse i_req with PUSH during LDD busy → ignored: no extra strobe, SP unchanged.
